// File: rtl/axi_llc_tag_bist_checker.sv
// rtl/axi_llc_tag_bist_checker.sv - LLC tag SRAM BIST read-back checker
// Optional first-fail index capture is built when AXI_LLC_TAG_BIST_FAIL_LOG_EN is defined.
package axi_llc_pkg;
    typedef struct packed {
        int unsigned SetAssociativity;
        int unsigned IndexLength;
    } llc_cfg_t;
endpackage

module axi_llc_tag_bist_checker #(
    parameter axi_llc_pkg::llc_cfg_t Cfg = axi_llc_pkg::llc_cfg_t'{default: '0},
    parameter type pattern_t             = logic,
    parameter type way_ind_t             = logic,
    parameter type index_t               = logic,
    parameter int unsigned ReadLatency   = 1,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_i,
    input  logic                              we_i,
    input  index_t                            index_i,
    input  pattern_t                          pattern_i,
    input  pattern_t [$bits(way_ind_t)-1:0]   rdata_i,
    input  logic                              clear_i,
    output way_ind_t                          bist_res_o,
    output logic                              bist_res_valid_o,
    output logic                              inflight_o,
    output way_ind_t                          fail_ways_o,
    output logic [CntWidth-1:0]               err_cnt_o,
    output logic                              first_fail_valid_o,
    output index_t                            first_fail_index_o
);

    localparam int unsigned Ways = $bits(way_ind_t);

    if (ReadLatency < 1 || ReadLatency > 4) begin : gen_bad_latency
        $error("ReadLatency must be within 1..4");
    end
    if (Cfg.SetAssociativity != 0 && Cfg.SetAssociativity != Ways) begin : gen_bad_ways
        $error("way_ind_t width does not match Cfg.SetAssociativity");
    end

    typedef struct packed {
        logic     valid;
        index_t   index;
        pattern_t pattern;
    } pipe_t;

    pipe_t pipe_q [ReadLatency];
    pipe_t tail;

    assign tail = pipe_q[ReadLatency-1];

    // Every cycle shifts; writes and idle cycles occupy a slot as bubbles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(ReadLatency); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].valid   <= req_i & ~we_i;
            pipe_q[0].index   <= index_i;
            pipe_q[0].pattern <= pattern_i;
            for (int i = 1; i < int'(ReadLatency); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    logic [Ways-1:0] match;

    always_comb begin
        match = '1;
        if (tail.valid) begin
            for (int w = 0; w < int'(Ways); w++) begin
                match[w] = (rdata_i[w] == tail.pattern);
            end
        end
    end

    logic [Ways-1:0] res_q;
    logic            res_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_q       <= '1;
            res_valid_q <= 1'b0;
        end else begin
            res_q       <= match;
            res_valid_q <= tail.valid;
        end
    end

    logic inflight;

    always_comb begin
        inflight = res_valid_q;
        for (int i = 0; i < int'(ReadLatency); i++) begin
            inflight = inflight | pipe_q[i].valid;
        end
    end

    logic [Ways-1:0]     fail;
    logic [Ways-1:0]     fail_ways_q;
    logic [CntWidth-1:0] err_cnt_q;

    assign fail = ~res_q;

    // Clear takes priority over a coincident failing result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            fail_ways_q <= '0;
            err_cnt_q   <= '0;
        end else if (res_valid_q) begin
            fail_ways_q <= fail_ways_q | fail;
            if (|fail && err_cnt_q != {CntWidth{1'b1}}) begin
                err_cnt_q <= err_cnt_q + CntWidth'(1);
            end
        end
    end

`ifdef AXI_LLC_TAG_BIST_FAIL_LOG_EN
    index_t res_index_q;
    logic   ff_valid_q;
    index_t ff_index_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_index_q <= '0;
        end else begin
            res_index_q <= tail.index;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            ff_valid_q <= 1'b0;
            ff_index_q <= '0;
        end else if (res_valid_q && |fail && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_index_q <= res_index_q;
        end
    end

    assign first_fail_valid_o = ff_valid_q;
    assign first_fail_index_o = ff_index_q;
`else
    logic unused_index;
    assign unused_index       = ^tail.index;
    assign first_fail_valid_o = 1'b0;
    assign first_fail_index_o = '0;
`endif

    assign bist_res_o       = way_ind_t'(res_q);
    assign bist_res_valid_o = res_valid_q;
    assign inflight_o       = inflight;
    assign fail_ways_o      = way_ind_t'(fail_ways_q);
    assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_axi_llc_tag_bist_checker.sv
// tb/tb_axi_llc_tag_bist_checker.sv - scoreboard bench for axi_llc_tag_bist_checker
// Two instances (latency 1 / 16-bit counter, latency 3 / 2-bit counter) share one stimulus stream.
module tb_axi_llc_tag_bist_checker;

    localparam int W  = 4;
    localparam int PW = 12;
    localparam int IW = 6;

    typedef logic [PW-1:0] pat_t;
    typedef logic [W-1:0]  way_t;
    typedef logic [IW-1:0] idx_t;

    localparam axi_llc_pkg::llc_cfg_t CfgT = '{SetAssociativity: 32'd4, IndexLength: 32'd6};

    typedef struct {
        int   due;
        int   sampled;
        way_t res;
        idx_t index;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n = 1'b0;
    logic req   = 1'b0;
    logic we    = 1'b0;
    logic clear = 1'b0;
    idx_t index = '0;
    pat_t pattern = '0;

    pat_t [W-1:0] rd_hist [4];
    pat_t [W-1:0] cur_data;
    pat_t [W-1:0] rdata_a, rdata_b;
    pat_t         mem [64];

    assign rdata_a = rd_hist[0];
    assign rdata_b = rd_hist[2];

    way_t        a_res, a_fw, b_res, b_fw;
    logic        a_valid, a_infl, a_ffv, b_valid, b_infl, b_ffv;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;
    idx_t        a_ffi, b_ffi;

    axi_llc_tag_bist_checker #(
        .Cfg(CfgT), .pattern_t(pat_t), .way_ind_t(way_t), .index_t(idx_t),
        .ReadLatency(1), .CntWidth(16)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .index_i(index),
        .pattern_i(pattern), .rdata_i(rdata_a), .clear_i(clear),
        .bist_res_o(a_res), .bist_res_valid_o(a_valid), .inflight_o(a_infl),
        .fail_ways_o(a_fw), .err_cnt_o(a_cnt),
        .first_fail_valid_o(a_ffv), .first_fail_index_o(a_ffi)
    );

    axi_llc_tag_bist_checker #(
        .Cfg(CfgT), .pattern_t(pat_t), .way_ind_t(way_t), .index_t(idx_t),
        .ReadLatency(3), .CntWidth(2)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .index_i(index),
        .pattern_i(pattern), .rdata_i(rdata_b), .clear_i(clear),
        .bist_res_o(b_res), .bist_res_valid_o(b_valid), .inflight_o(b_infl),
        .fail_ways_o(b_fw), .err_cnt_o(b_cnt),
        .first_fail_valid_o(b_ffv), .first_fail_index_o(b_ffi)
    );

    exp_t sb [2][$];
    way_t m_fw  [2];
    int   m_cnt [2];
    logic m_ffv [2];
    idx_t m_ffi [2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input int id, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", id, name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input int cmax, input logic v, input way_t res, input logic infl,
                       input way_t fw, input int cnt, input logic ffv, input idx_t ffi);
        exp_t e;
        bit   have;
        bit   exp_infl;
        if (!rst_n) begin
            sb[id].delete();
            m_fw[id]  = '0;
            m_cnt[id] = 0;
            m_ffv[id] = 1'b0;
            m_ffi[id] = '0;
            return;
        end
        chk(id, "fail_ways", 64'(fw), 64'(m_fw[id]));
        chk(id, "err_cnt", 64'(cnt), 64'(m_cnt[id]));
`ifdef AXI_LLC_TAG_BIST_FAIL_LOG_EN
        chk(id, "first_fail_valid", 64'(ffv), 64'(m_ffv[id]));
        chk(id, "first_fail_index", 64'(ffi), 64'(m_ffi[id]));
`else
        chk(id, "first_fail_valid", 64'(ffv), 64'd0);
        chk(id, "first_fail_index", 64'(ffi), 64'd0);
`endif
        exp_infl = (sb[id].size() > 0) && (sb[id][0].sampled <= cyc);
        chk(id, "inflight", 64'(infl), 64'(exp_infl));
        have = 1'b0;
        if (v) begin
            if (sb[id].size() == 0) begin
                chk(id, "unexpected_result", 64'(v), 64'd0);
            end else begin
                e    = sb[id].pop_front();
                have = 1'b1;
                chk(id, "bist_res", 64'(res), 64'(e.res));
                chk(id, "latency", 64'(cyc), 64'(e.due));
            end
        end else begin
            chk(id, "idle_res", 64'(res), 64'({W{1'b1}}));
            if (sb[id].size() > 0 && sb[id][0].due < cyc) begin
                chk(id, "missing_result", 64'(v), 64'd1);
                void'(sb[id].pop_front());
            end
        end
        if (clear) begin
            m_fw[id]  = '0;
            m_cnt[id] = 0;
            m_ffv[id] = 1'b0;
            m_ffi[id] = '0;
        end else if (have && e.res != {W{1'b1}}) begin
            m_fw[id] = m_fw[id] | ~e.res;
            if (m_cnt[id] < cmax) m_cnt[id]++;
            if (!m_ffv[id]) begin
                m_ffv[id] = 1'b1;
                m_ffi[id] = e.index;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, 65535, a_valid, a_res, a_infl, a_fw, int'(a_cnt), a_ffv, a_ffi);
        mon(1, 3,     b_valid, b_res, b_infl, b_fw, int'(b_cnt), b_ffv, b_ffi);
    end

    // One cycle of stimulus; reads are answered by a behavioural SRAM with optional bit-0 corruption per way.
    task automatic step(input logic rs, input logic r, input logic wr, input idx_t i,
                        input pat_t p, input way_t bad, input logic clr);
        exp_t e;
        @(posedge clk);
        #1;
        for (int k = 3; k > 0; k--) rd_hist[k] = rd_hist[k-1];
        rd_hist[0] = cur_data;
        rst_n   = rs;
        req     = r;
        we      = wr;
        index   = i;
        pattern = p;
        clear   = clr;
        for (int w = 0; w < W; w++) cur_data[w] = pat_t'($urandom);
        if (rs && r && wr) mem[i] = p;
        if (rs && r && !wr) begin
            for (int w = 0; w < W; w++) begin
                cur_data[w] = mem[i] ^ (bad[w] ? pat_t'(1) : pat_t'(0));
                e.res[w]    = (cur_data[w] == p);
            end
            e.index   = i;
            e.sampled = cyc + 1;
            e.due     = cyc + 2;
            sb[0].push_back(e);
            e.due     = cyc + 4;
            sb[1].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        idx_t ri;
        pat_t rp;
        for (int k = 0; k < 64; k++) mem[k] = '0;
        for (int k = 0; k < 4; k++) rd_hist[k] = '0;
        cur_data = '0;

        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        chk(0, "reset_res", 64'(a_res), 64'({W{1'b1}}));
        chk(0, "reset_valid", 64'(a_valid), 64'd0);

        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1, idx_t'(k), '0, '0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, idx_t'(k), '0, '0, 1'b0);
        idle(6);
        chk(0, "tp1_err_cnt", 64'(a_cnt), 64'd0);

        step(1'b1, 1'b1, 1'b1, idx_t'(5), {PW{1'b1}}, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, idx_t'(5), {PW{1'b1}}, 4'b0100, 1'b0);
        idle(6);
        chk(0, "tp2_fail_ways", 64'(a_fw), 64'h4);
        chk(0, "tp2_err_cnt", 64'(a_cnt), 64'd1);
`ifdef AXI_LLC_TAG_BIST_FAIL_LOG_EN
        chk(0, "tp2_first_fail_index", 64'(a_ffi), 64'd5);
`endif

        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        step(1'b1, 1'b1, 1'b0, idx_t'(3), '0, 4'b0001, 1'b0);
        step(1'b1, 1'b1, 1'b0, idx_t'(9), '0, 4'b1000, 1'b0);
        idle(6);
        chk(0, "tp3_err_cnt", 64'(a_cnt), 64'd2);
`ifdef AXI_LLC_TAG_BIST_FAIL_LOG_EN
        chk(0, "tp3_first_fail_index", 64'(a_ffi), 64'd3);
`endif

        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, idx_t'(10 + k), '0, 4'b1111, 1'b0);
        idle(6);
        chk(1, "tp4_err_cnt_sat", 64'(b_cnt), 64'd3);

        step(1'b1, 1'b1, 1'b0, idx_t'(4), '0, 4'b0010, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        idle(1);
        chk(0, "tp5_clear_fail_ways", 64'(a_fw), 64'd0);
        chk(0, "tp5_clear_err_cnt", 64'(a_cnt), 64'd0);
        idle(4);

        step(1'b1, 1'b1, 1'b0, idx_t'(6), '0, 4'b0001, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, idx_t'(2), '0, '0, 1'b0);
        idle(6);

        for (int k = 0; k < 400; k++) begin
            ri = idx_t'($urandom_range(0, 63));
            rp = ($urandom_range(0, 3) == 0) ? pat_t'($urandom) : mem[ri];
            step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ri, rp,
                 ($urandom_range(0, 3) == 0) ? way_t'($urandom) : '0,
                 ($urandom_range(0, 40) == 0));
        end
        idle(8);
        chk(0, "drain", 64'(sb[0].size()), 64'd0);
        chk(1, "drain", 64'(sb[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
